// File: rtl/rr_data_selector.sv
// rr_data_selector: arbitrates SEL_WIDTH valid/ready requesters onto one registered output channel.
// Define RR_DATA_SELECTOR_ROUND_ROBIN_EN for round-robin; the default build is fixed priority (lowest index wins).
module rr_data_selector #(
  parameter int SEL_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [SEL_WIDTH-1:0]  req_valid_in,
  output logic [SEL_WIDTH-1:0]  req_ready_out,
  input  logic [DATA_WIDTH-1:0] data_in [SEL_WIDTH],
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [ID_WIDTH-1:0]   grant_id_out
);
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]   out_id;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   win;
  logic                  hit;
  logic                  go;
  // Scan starts at rr_ptr and wraps, so the first valid requester after the last winner is chosen.
  always_comb begin
    int j;
    j = 0;
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      j = int'(rr_ptr) + k;
      j = (j >= SEL_WIDTH) ? j - SEL_WIDTH : j;
      if (!hit && req_valid_in[j]) begin
        hit = 1'b1;
        win = ID_WIDTH'(j);
      end
    end
  end
  assign go = rst && (!out_valid || data_out_ready) && !flush && hit;
  assign req_ready_out = go ? (SEL_WIDTH'(1) << win) : '0;
  assign data_out = out_data;
  assign data_out_valid = out_valid;
  assign grant_id_out = out_id;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (go) begin
      out_valid <= 1'b1;
      out_data <= data_in[win];
      out_id <= win;
    end else if (data_out_ready) begin
      out_valid <= 1'b0;
    end
  end
`ifdef RR_DATA_SELECTOR_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr <= '0;
    else if (go) rr_ptr <= (int'(win) == SEL_WIDTH - 1) ? '0 : win + 1'b1;
  end
`else
  assign rr_ptr = '0;
`endif
endmodule

// File: doc/rr_data_selector.md
Name: rr_data_selector

Overview:
- Registered, arbitrated successor to the one-hot OR-reduction selector.
- SEL_WIDTH requesters, each with a valid/ready handshake, compete for one registered output channel.
- Exactly one requester is granted per cycle: round-robin, or fixed priority when built without RR.
- Used wherever several units share one downstream port, e.g. writeback or CSR/commit paths, and a one-hot select supplied by the caller is no longer guaranteed.

Parameters:
- SEL_WIDTH, 5, number of requesters; minimum 1.
- DATA_WIDTH, 32, payload width in bits.
- ID_WIDTH, (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1, width of the granted-index output.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; state is reset while rst == 0.
- flush  input  1  synchronous flush; drops the held output entry.
- req_valid_in  input  SEL_WIDTH  per-requester valid.
- req_ready_out  output  SEL_WIDTH  one-hot (or zero) accept; requester i is consumed when req_valid_in[i] && req_ready_out[i].
- data_in  input  DATA_WIDTH x [0:SEL_WIDTH-1]  per-requester payload.
- data_out  output  DATA_WIDTH  registered payload.
- data_out_valid  output  1  output register holds an entry.
- data_out_ready  input  1  downstream accepts data_out this cycle.
- grant_id_out  output  ID_WIDTH  index of the requester whose payload is in data_out.

Behaviour:
- State:
  - out_valid: 1 bit.
  - out_data: DATA_WIDTH bits.
  - out_id: ID_WIDTH bits.
  - rr_ptr: ID_WIDTH bits, range 0..SEL_WIDTH-1.
- Reset (rst == 0, asynchronous): out_valid = 0, out_data = 0, out_id = 0, rr_ptr = 0. Outputs data_out_valid = 0, data_out = 0, grant_id_out = 0, req_ready_out = 0 while in reset.
- can_load = !out_valid || data_out_ready. This allows full throughput with one register stage.
- Arbitration, combinational, evaluated only when can_load && !flush:
  - The winner is the first i with req_valid_in[i] = 1, scanning rr_ptr, rr_ptr+1, ... modulo SEL_WIDTH.
  - req_ready_out has only the winner's bit set. It is all-zero when there is no request, when !can_load, or when flush = 1.
  - req_ready_out never depends on req_valid_in of the same index in a way that asserts ready without valid.
- Load on handshake: out_data <= data_in[winner], out_id <= winner, out_valid <= 1, rr_ptr <= (winner == SEL_WIDTH-1) ? 0 : winner+1.
- Drain without refill: when data_out_valid && data_out_ready and there is no winner, out_valid <= 0. out_data and out_id hold their values.
- Latency: a request accepted in cycle N appears on data_out in cycle N+1. Throughput is one item per cycle while data_out_ready = 1.
- Backpressure: while out_valid && !data_out_ready, data_out and grant_id_out are stable and all req_ready_out = 0.
- Flush: out_valid <= 0 on the next edge and nothing is accepted that cycle. rr_ptr is unchanged. flush overrides a simultaneous load or drain.
- Fairness: with all requesters continuously valid and data_out_ready = 1, grants cycle 0,1,...,SEL_WIDTH-1,0,...
- Wrap-around: rr_ptr = SEL_WIDTH-1 with only requester 0 valid grants requester 0, and rr_ptr becomes 1.
- SEL_WIDTH == 1: rr_ptr stays 0; the block degenerates to a one-entry pipeline register.
- Mid-operation reset: any held entry is lost and the pointer returns to 0. No partial handshake survives.

Optional Feature:
- Macro: RR_DATA_SELECTOR_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority, lowest index wins. rr_ptr is removed, or tied to 0 and never updated. All other timing and handshake rules are identical.

Test Plan (SEL_WIDTH = 5, DATA_WIDTH = 32, RR enabled unless noted):
- Reset held 3 cycles with req_valid_in = 5'b11111 -> data_out_valid = 0, req_ready_out = 0. The first release cycle grants requester 0; the next cycle shows data_out = data_in[0] and grant_id_out = 0.
- All five valid, data_in[i] = 32'hA0+i, data_out_ready = 1 for 10 cycles -> data_out sequence A0,A1,A2,A3,A4,A0,... one per cycle, each requester accepted exactly twice.
- Entry 32'hDEAD held, data_out_ready = 0 for 4 cycles with requesters valid -> data_out stable at DEAD, req_ready_out = 0. When ready rises, a new grant the same cycle and the next data appears one cycle later, with no bubble.
- rr_ptr = 4 (after granting 3), only req_valid_in[0] = 1 -> requester 0 granted, rr_ptr becomes 1.
- flush = 1 while data_out_valid = 1 and requester 2 is valid -> next cycle data_out_valid = 0, requester 2 not consumed that cycle, rr_ptr unchanged.
- Macro undefined, requesters 1 and 3 continuously valid -> requester 1 granted every cycle and requester 3 never granted.
